// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : mul_pkg

// File: rtl/seq_shift_add_multiplier_add_w1.sv
// Parameterised adder with carry-in: partial-product step and final two's-complement negate.
module add_w1 #(
    parameter int unsigned N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_c
);

    assign sum_c = a_i + b_i + N'(cin_i);

endmodule : add_w1

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier, W x W -> 2W, unsigned or signed per transaction.
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned W     = MUL_W_DEFAULT,
    parameter int unsigned CNT_W = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           busy
);

    mul_state_t         state_q, state_d;
    logic [2*W:0]       p_q, p_d;
    logic [W-1:0]       mag_a_q, mag_a_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     out_prod_q, out_prod_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [W-1:0]       mag_a_c, mag_b_c;
    logic [W:0]         pp_sum_c, p_hi_c;
    logic [2*W:0]       p_shift_c;
    logic [2*W-1:0]     res_c, neg_sum_c;

    // Partial-product add on the upper half of P
    add_w1 #(.N(W + 1)) u_pp_add (
        .a_i   ({1'b0, p_q[2*W-1:W]}),
        .b_i   ({1'b0, mag_a_q}),
        .cin_i (1'b0),
        .sum_c (pp_sum_c)
    );

    assign p_hi_c    = p_q[0] ? pp_sum_c : p_q[2*W:W];
    assign p_shift_c = {1'b0, p_hi_c, p_q[W-1:1]};
    assign res_c     = p_shift_c[2*W-1:0];

    // Negate as ~res + 1 through the same adder structure
    add_w1 #(.N(2 * W)) u_neg (
        .a_i   (~res_c),
        .b_i   ({(2*W){1'b0}}),
        .cin_i (1'b1),
        .sum_c (neg_sum_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            mag_a_q     <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            out_prod_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            mag_a_q     <= mag_a_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            out_prod_q  <= out_prod_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        mag_a_d     = mag_a_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        out_prod_d  = out_prod_q;
        out_valid_d = out_valid_q;
        mag_a_c     = in_a;
        mag_b_c     = in_b;

        // Magnitudes for signed mode; |-2^(W-1)| still fits in W bits
        if (in_signed) begin
            if (in_a[W-1]) mag_a_c = ~in_a + W'(1);
            if (in_b[W-1]) mag_b_c = ~in_b + W'(1);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_a_d = mag_a_c;
                    neg_d   = in_signed & (in_a[W-1] ^ in_b[W-1]);
                    p_d     = {1'b0, {W{1'b0}}, mag_b_c};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = p_shift_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    out_prod_d  = neg_q ? neg_sum_c : res_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign busy      = busy_q;

endmodule : seq_shift_add_multiplier

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: transaction-level model plus directed vectors with literal products.
module tb_seq_shift_add_multiplier;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_prod;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_shift_add_multiplier #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: sign/zero-extend to 2W bits and multiply
    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic s);
        logic [2*W-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Transaction model: one product in flight, ready W edges after accept
    logic           m_busy  = 1'b0;
    logic           m_valid = 1'b0;
    logic [2*W-1:0] m_pend  = '0;
    logic [2*W-1:0] m_out   = '0;
    int             m_left  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_out   = '0;
            m_left  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_pend = model_prod(in_a, in_b, in_signed);
                m_left = W;
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_out   = m_pend;
            end
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("cmp out_valid", 64'(out_valid), 64'(m_valid));
        check("cmp in_ready", 64'(in_ready), 64'(!m_busy));
        check("cmp busy", 64'(busy), 64'(m_busy));
        check("cmp out_prod", 64'(out_prod), 64'(m_out));
    end

    // Single transaction with out_ready held high; checks latency, product and pulse width
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp);
        int n;
        @(negedge clk);
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        check({name, " latency"}, 64'(n), 64'(W));
        check({name, " prod"}, 64'(out_prod), 64'(exp));
        @(negedge clk);
        check({name, " pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_prod", 64'(out_prod), 64'd0);

        do_op("u3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F);
        do_op("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        do_op("u0x1234", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000);
        do_op("s-1x1", 16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF);
        do_op("s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        do_op("s8000x7FFF", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
        do_op("s-5x0", 16'hFFFB, 16'h0000, 1'b1, 32'h0000_0000);

        // Backpressure: result must hold while inputs wiggle
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'd7;
        in_b      = 16'd9;
        in_signed = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        check("bp latency", 64'(n), 64'(W));
        for (int i = 0; i < 5; i++) begin
            check("bp prod", 64'(out_prod), 64'h3F);
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp busy", 64'(busy), 64'd1);
            in_valid = i[0];
            in_a     = W'(i * 1111);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp released", 64'(out_valid), 64'd0);
        check("bp idle", 64'(in_ready), 64'd1);
        check("bp held prod", 64'(out_prod), 64'h3F);

        // Reset mid-operation, after iteration 8
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h5678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("after rst 2x3", 16'd2, 16'd3, 1'b0, 32'h0000_0006);

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b2b ready", 64'(in_ready), 64'd1);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_signed = 1'($urandom_range(0, 1));
            acc[i]    = cyc;
            if (i > 0) check("b2b spacing", 64'(acc[i] - acc[i-1]), 64'(W + 2));
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b drained", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_shift_add_multiplier
